// File: rtl/mem_pkg.sv
// Shared slot indices, FSM state type and default line width for the L2 port arbiter.
package mem_pkg;

    localparam int LINE_W = 256;

    localparam int REQ_ICACHE   = 0;
    localparam int REQ_DCACHE   = 1;
    localparam int REQ_IOMMU    = 2;
    localparam int REQ_PREFETCH = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational 3-way round-robin selector for the demand clients.
module rr_picker (
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [2:0] gnt,
    output logic       valid
);

    // Search starts at ptr and wraps; an out-of-range ptr falls back to slot 0 first.
    always_comb begin
        gnt = 3'b000;
        case (ptr)
            2'd1: begin
                if (req[1])      gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else             gnt = 3'b000;
            end
            2'd2: begin
                if (req[2])      gnt = 3'b100;
                else if (req[0]) gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else             gnt = 3'b000;
            end
            default: begin
                if (req[0])      gnt = 3'b001;
                else if (req[1]) gnt = 3'b010;
                else if (req[2]) gnt = 3'b100;
                else             gnt = 3'b000;
            end
        endcase
        valid = |req;
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Single-owner arbiter for the shared L2 request port: round-robin demand clients,
// opportunistic prefetch with starvation promotion, and a BUSY timeout watchdog.
module l2_port_arbiter #(
    parameter int LINE_W          = mem_pkg::LINE_W,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int PF_STARVE_LIMIT = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          req,
    input  logic [4*32-1:0]     req_addr,
    input  logic [3:0]          req_write_en,
    input  logic [4*LINE_W-1:0] req_write_data,
    output logic [3:0]          grant,
    output logic [3:0]          done,
    output logic [3:0]          err,
    output logic [LINE_W-1:0]   rdata,
    output logic [31:0]         l2_addr,
    output logic                l2_request,
    output logic                l2_write_en,
    output logic [LINE_W-1:0]   l2_write_data,
    input  logic [LINE_W-1:0]   l2_data,
    input  logic                l2_done,
    output logic                busy
);
    import mem_pkg::*;

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SCNT_W = $clog2(PF_STARVE_LIMIT + 1);
    localparam logic [TCNT_W-1:0] TCNT_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [SCNT_W-1:0] STARVE_MAX = SCNT_W'(PF_STARVE_LIMIT);

    arb_state_t          r_state;
    logic [1:0]          r_rr_ptr;
    logic [1:0]          r_owner;
    logic [SCNT_W-1:0]   r_starve_cnt;
    logic [TCNT_W-1:0]   r_tcnt;
    logic [3:0]          r_grant;
    logic [3:0]          r_done;
    logic [3:0]          r_err;
    logic [LINE_W-1:0]   r_rdata;
    logic [31:0]         r_l2_addr;
    logic                r_l2_request;
    logic                r_l2_write_en;
    logic [LINE_W-1:0]   r_l2_write_data;
    logic                r_busy;

    logic [2:0]          w_demand_gnt;
    logic                w_demand_valid;
    logic                w_pf_promote;
    logic [3:0]          w_win;
    logic [1:0]          w_win_idx;
    logic [1:0]          w_next_ptr;
    logic                w_win_we;

    rr_picker u_rr_picker (
        .req   (req[2:0]),
        .ptr   (r_rr_ptr),
        .gnt   (w_demand_gnt),
        .valid (w_demand_valid)
    );

    assign w_pf_promote = req[REQ_PREFETCH] && (r_starve_cnt >= STARVE_MAX);

    // Winner: starved prefetch first, then round-robin demand, then idle-time prefetch.
    always_comb begin
        w_win = 4'b0000;
        if (w_pf_promote)              w_win = 4'b1000;
        else if (w_demand_valid)       w_win = {1'b0, w_demand_gnt};
        else if (req[REQ_PREFETCH])    w_win = 4'b1000;
        else                           w_win = 4'b0000;
    end

    // Encode winner index, next round-robin pointer and masked write flag.
    always_comb begin
        w_win_idx  = 2'd0;
        w_next_ptr = r_rr_ptr;
        case (w_win)
            4'b0001: begin w_win_idx = 2'd0; w_next_ptr = 2'd1; end
            4'b0010: begin w_win_idx = 2'd1; w_next_ptr = 2'd2; end
            4'b0100: begin w_win_idx = 2'd2; w_next_ptr = 2'd0; end
            4'b1000: begin w_win_idx = 2'd3; w_next_ptr = r_rr_ptr; end
            default: begin w_win_idx = 2'd0; w_next_ptr = r_rr_ptr; end
        endcase
        w_win_we = req_write_en[w_win_idx] &&
                   ((w_win_idx == 2'(REQ_DCACHE)) || (w_win_idx == 2'(REQ_IOMMU)));
    end

    // Arbiter FSM with starvation counter, timeout counter and operand registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_rr_ptr        <= 2'd0;
            r_owner         <= 2'd0;
            r_starve_cnt    <= '0;
            r_tcnt          <= '0;
            r_grant         <= 4'b0000;
            r_done          <= 4'b0000;
            r_err           <= 4'b0000;
            r_rdata         <= '0;
            r_l2_addr       <= 32'h0000_0000;
            r_l2_request    <= 1'b0;
            r_l2_write_en   <= 1'b0;
            r_l2_write_data <= '0;
            r_busy          <= 1'b0;
        end else begin
            if (!req[REQ_PREFETCH] || r_grant[REQ_PREFETCH])
                r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_MAX)
                r_starve_cnt <= r_starve_cnt + SCNT_W'(1);
            else
                r_starve_cnt <= r_starve_cnt;

            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_owner         <= w_win_idx;
                        r_grant         <= w_win;
                        r_l2_addr       <= req_addr[{w_win_idx, 5'd0} +: 32];
                        r_l2_write_en   <= w_win_we;
                        r_l2_write_data <= req_write_data[int'(w_win_idx) * LINE_W +: LINE_W];
                        r_l2_request    <= 1'b1;
                        r_tcnt          <= '0;
                        r_busy          <= 1'b1;
                        r_rr_ptr        <= w_next_ptr;
                        r_state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (l2_done) begin
                        r_rdata          <= l2_data;
                        r_done[r_owner]  <= 1'b1;
                        r_l2_request     <= 1'b0;
                        r_state          <= RESP;
                    end else if (r_tcnt == TCNT_LAST) begin
                        r_rdata          <= '0;
                        r_done[r_owner]  <= 1'b1;
                        r_err[r_owner]   <= 1'b1;
                        r_l2_request     <= 1'b0;
                        r_state          <= RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TCNT_W'(1);
                    end
                end
                RESP: begin
                    r_grant <= 4'b0000;
                    r_done  <= 4'b0000;
                    r_err   <= 4'b0000;
                    r_rdata <= '0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign grant         = r_grant;
    assign done          = r_done;
    assign err           = r_err;
    assign rdata         = r_rdata;
    assign l2_addr       = r_l2_addr;
    assign l2_request    = r_l2_request;
    assign l2_write_en   = r_l2_write_en;
    assign l2_write_data = r_l2_write_data;
    assign busy          = r_busy;

endmodule
